memoria_datos_lsu: RTL

Parametrised load/store unit with integrated data memory; successor to the single-cycle data memory on the core's ALU-result/RS2 path. Supports all RV32I load/store widths (byte/half/word, signed/unsigned), little-endian byte lanes, configurable wait states, a valid/ready request handshake, and an error response for misaligned, out-of-range or illegal accesses. The core stalls on `req_ready`/`resp_valid`, so this block enables multi-cycle memory.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_formato_carga.sv | 29 ++
 rtl/memoria_datos_lsu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM encoding
// and the legality/alignment check used on every request.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // True when funct3 is a legal code for the direction and the byte offset
    // is naturally aligned for the access width.
    function automatic logic is_legal(input logic       wr,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (wr) begin
            case (f3)
                SB:      ok = 1'b1;
                SH:      ok = ~off[0];
                SW:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LB, LBU: ok = 1'b1;
                LH, LHU: ok = ~off[0];
                LW:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_formato_carga.sv
// Load formatter: selects the byte/half/word lane from a memory word and
// sign- or zero-extends it according to funct3.
module lsu_formato_carga
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*byte_off_i +: 8];
        half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        case (funct3_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LW:      data_o = word_i;
            LBU:     data_o = {24'd0, byte_sel};
            LHU:     data_o = {16'd0, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/memoria_datos_lsu.sv
// Load/store unit with integrated byte-lane data memory, valid/ready request
// handshake, configurable wait states and an error response.
module memoria_datos_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         BYTE_W   = IDX_W + 2;
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    lsu_state_e        state_q;
    logic [2:0]        cnt_q;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              accept;
    logic              do_access;
    logic              acc_wr;
    logic [2:0]        acc_f3;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_ok;
    logic [IDX_W-1:0]  acc_idx;
    logic [31:0]       load_val;
    logic [3:0]        st_be;
    logic [31:0]       st_data;
    logic              mem_we;

    assign req_ready = (state_q != ST_WAIT);
    assign accept    = req_valid & req_ready & reset;
    assign do_access = ((WAIT_STATES == 0) && accept) || (state_q == ST_WAIT && cnt_q == 3'd0);

    // With no wait states the access happens on the accept edge itself, so it
    // must use the live request; otherwise it uses the captured copy.
    always_comb begin
        if (state_q == ST_WAIT) begin
            acc_wr    = wr_q;
            acc_f3    = f3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end else begin
            acc_wr    = req_write;
            acc_f3    = funct3;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign acc_ok  = is_legal(acc_wr, acc_f3, acc_addr[1:0]) && ((acc_addr >> BYTE_W) == '0);
    assign acc_idx = acc_addr[BYTE_W-1:2];
    assign mem_we  = reset & do_access & acc_wr & acc_ok;

    always_comb begin
        st_be   = 4'b0000;
        st_data = acc_wdata;
        case (acc_f3)
            SB: begin
                st_be   = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            SH: begin
                st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            SW:      st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    lsu_formato_carga u_formato (
        .word_i     (mem_q[acc_idx]),
        .byte_off_i (acc_addr[1:0]),
        .funct3_i   (acc_f3),
        .data_o     (load_val)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && st_be[b]) begin
                mem_q[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (do_access) begin
                resp_valid <= 1'b1;
                resp_err   <= ~acc_ok;
                resp_rdata <= (acc_ok && !acc_wr) ? load_val : 32'd0;
            end
        end
    end

endmodule
